// File: rtl/dvfs_seq_ctrl.sv
// Multi-domain DVFS controller.
// Picks one global power mode from the perf, thermal, battery and idle inputs,
// applying hysteresis and a minimum dwell time. Each V/F domain then walks its
// levels one step at a time toward that mode's target. Frequency drops before
// voltage drops, and voltage rises before frequency rises.
module dvfs_seq_ctrl #(
  parameter int NUM_DOM = 3,
  parameter int VW      = 2,
  parameter int FW      = 3,
  parameter int SETTLE  = 4,
  parameter int DWELL   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  perf_req,
  input  logic [1:0]            temp_lvl,
  input  logic [1:0]            batt_lvl,
  input  logic [NUM_DOM-1:0]    dom_idle,
  output logic [NUM_DOM*VW-1:0] vlevel,
  output logic [NUM_DOM*FW-1:0] flevel,
  output logic [2:0]            mode,
  output logic                  power_save,
  output logic [NUM_DOM-1:0]    busy
);

  typedef enum logic [2:0] {
    M_NORMAL  = 3'd0,
    M_PERF    = 3'd1,
    M_PSAVE   = 3'd2,
    M_THERMAL = 3'd3,
    M_BATT    = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_DN,
    S_V_STEP,
    S_V_SETTLE,
    S_F_UP
  } seq_e;

  localparam logic [VW-1:0] VMAX = '1;
  localparam logic [FW-1:0] FMAX = '1;
  localparam int DCW = $clog2(DWELL + 1);
  localparam int SCW = $clog2(SETTLE + 1);
  localparam logic [DCW-1:0] DWELL_MAX   = DCW'(DWELL);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

  mode_e          mode_r;
  mode_e          mode_req;
  logic [DCW-1:0] dwell_cnt;
  logic           mode_take;

  logic [VW-1:0]  tgt_v [NUM_DOM];
  logic [FW-1:0]  tgt_f [NUM_DOM];

  // Requested mode. Battery outranks thermal. Both urgent modes hold until their input clears.
  always_comb begin
    // NOTE: a complete if/else chain assigns mode_req on every path, so no latch is inferred.
    if (mode_r == M_BATT && batt_lvl < 2'd2)            mode_req = M_BATT;
    else if (batt_lvl == 2'd0)                          mode_req = M_BATT;
    else if (mode_r == M_THERMAL && temp_lvl != 2'd0)   mode_req = M_THERMAL;
    else if (temp_lvl >= 2'd2)                          mode_req = M_THERMAL;
    else if (perf_req)                                  mode_req = M_PERF;
    else if (&dom_idle)                                 mode_req = M_PSAVE;
    else                                                mode_req = M_NORMAL;
  end

  // Urgent modes are entered at once. Any other change waits for the dwell counter to fill.
  assign mode_take = (mode_req != mode_r) &&
                     (mode_req == M_BATT || mode_req == M_THERMAL || dwell_cnt == DWELL_MAX);

  // Mode register, saturating dwell counter and registered power_save flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      mode_r     <= M_NORMAL;
      dwell_cnt  <= '0;
      power_save <= 1'b0;
    end else if (mode_take) begin
      mode_r     <= mode_req;
      dwell_cnt  <= '0;
      power_save <= (mode_req == M_PSAVE) || (mode_req == M_BATT);
    end else if (dwell_cnt != DWELL_MAX) begin
      dwell_cnt  <= dwell_cnt + 1'b1;
    end
  end

  assign mode = mode_r;

  // Per-domain (V,F) target for the current mode. Idle domains in NORMAL or PERF fall back to PSAVE levels.
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      tgt_v[d] = '0;
      tgt_f[d] = '0;
      case (mode_r)
        M_NORMAL:  begin tgt_v[d] = VMAX >> 1; tgt_f[d] = FMAX >> 1; end
        M_PERF:    begin tgt_v[d] = VMAX;      tgt_f[d] = FMAX;      end
        M_THERMAL: begin tgt_v[d] = VMAX >> 1; tgt_f[d] = FMAX >> 2; end
        M_PSAVE:   begin tgt_v[d] = '0;        tgt_f[d] = FW'(1);    end
        default:   begin tgt_v[d] = '0;        tgt_f[d] = '0;        end
      endcase
      if ((mode_r == M_NORMAL || mode_r == M_PERF) && dom_idle[d]) begin
        tgt_v[d] = '0;
        tgt_f[d] = FW'(1);
      end
    end
  end

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    seq_e           state;
    logic [VW-1:0]  v_cur;
    logic [VW-1:0]  v_goal;
    logic [FW-1:0]  f_cur;
    logic [FW-1:0]  f_goal;
    logic [SCW-1:0] settle_cnt;
    logic           seq_busy;

    // Ramp sequencer. The goal is latched when a sequence starts, so a later target change waits for IDLE.
    // The guards (f > goal, v < goal, ...) keep every step inside 0..MAX without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= S_IDLE;
        v_cur      <= '0;
        v_goal     <= '0;
        f_cur      <= '0;
        f_goal     <= '0;
        settle_cnt <= '0;
        seq_busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (tgt_v[d] != v_cur || tgt_f[d] != f_cur) begin
              v_goal   <= tgt_v[d];
              f_goal   <= tgt_f[d];
              seq_busy <= 1'b1;
              state    <= S_F_DN;
            end
          end
          S_F_DN: begin
            if (f_cur > f_goal) f_cur <= f_cur - 1'b1;
            else                state <= S_V_STEP;
          end
          S_V_STEP: begin
            if (v_cur < v_goal) begin
              v_cur      <= v_cur + 1'b1;
              settle_cnt <= '0;
              state      <= S_V_SETTLE;
            end else if (v_cur > v_goal) begin
              v_cur      <= v_cur - 1'b1;
              settle_cnt <= '0;
              state      <= S_V_SETTLE;
            end else begin
              state      <= S_F_UP;
            end
          end
          S_V_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state      <= S_V_STEP;
            else                           settle_cnt <= settle_cnt + 1'b1;
          end
          S_F_UP: begin
            if (f_cur < f_goal) begin
              f_cur <= f_cur + 1'b1;
            end else begin
              seq_busy <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    assign vlevel[d*VW +: VW] = v_cur;
    assign flevel[d*FW +: FW] = f_cur;
    assign busy[d]            = seq_busy;
  end

endmodule
